// File: rtl/ps2_mouse_packet.sv
// PS/2 mouse packet assembler.
// Collects 3-byte mouse packets from the received-byte stream, checks the
// header framing bit, recovers from lost bytes with an inter-byte timeout,
// and tracks a clamped absolute cursor position.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   WAIT_B0 | idle, expecting a header byte (bit 3 set)
//   WAIT_B1 | header latched, expecting the X movement byte
//   WAIT_B2 | X byte latched, expecting the Y movement byte
module ps2_mouse_packet #(
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_en,
    output logic        packet_valid,
    output logic [2:0]  buttons,
    output logic [8:0]  dx,
    output logic [8:0]  dy,
    output logic [11:0] pos_x,
    output logic [11:0] pos_y,
    output logic        sync_err
);

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2
    } state_t;

    localparam logic [16:0]        TMO_LIM = 17'(TIMEOUT_CYCLES);
    localparam logic signed [13:0] X_MAX   = 14'(SCREEN_W - 1);
    localparam logic signed [13:0] Y_MAX   = 14'(SCREEN_H - 1);
    localparam logic [11:0]        X_RST   = 12'(SCREEN_W / 2);
    localparam logic [11:0]        Y_RST   = 12'(SCREEN_H / 2);
    localparam logic [7:0]         B_ACK   = 8'hFA;
    localparam logic [7:0]         B_BAT   = 8'hAA;

    // Header fields kept from byte0 (bit 3 is always 1 and not stored):
    // [6]=Y overflow, [5]=X overflow, [4]=Y sign, [3]=X sign, [2:0]=buttons
    state_t      state_q, state_d;
    logic [6:0]  hdr_q, hdr_d;
    logic [7:0]  byte1_q, byte1_d;
    logic        first_q, first_d;
    logic [16:0] tmo_cnt_q, tmo_cnt_d;
    logic        packet_valid_q, packet_valid_d;
    logic        sync_err_q, sync_err_d;
    logic [2:0]  buttons_q, buttons_d;
    logic [8:0]  dx_q, dx_d;
    logic [8:0]  dy_q, dy_d;
    logic [11:0] pos_x_q, pos_x_d;
    logic [11:0] pos_y_q, pos_y_d;

    logic [8:0]         new_dx, new_dy;
    logic signed [13:0] nx, ny;
    logic [11:0]        clamp_x, clamp_y;
    logic               tmo_hit;

    // Deltas of the packet completing this cycle (byte2 is rx_data) and the
    // resulting clamped position; 14-bit signed so nothing wraps pre-clamp.
    always_comb begin
        new_dx = hdr_q[5] ? 9'd0 : {hdr_q[3], byte1_q};
        new_dy = hdr_q[6] ? 9'd0 : {hdr_q[4], rx_data};
        nx = $signed({2'b00, pos_x_q}) + $signed({{5{new_dx[8]}}, new_dx});
        ny = $signed({2'b00, pos_y_q}) - $signed({{5{new_dy[8]}}, new_dy});
        if (nx < 14'sd0) begin
            clamp_x = 12'd0;
        end else if (nx > X_MAX) begin
            clamp_x = X_MAX[11:0];
        end else begin
            clamp_x = nx[11:0];
        end
        if (ny < 14'sd0) begin
            clamp_y = 12'd0;
        end else if (ny > Y_MAX) begin
            clamp_y = Y_MAX[11:0];
        end else begin
            clamp_y = ny[11:0];
        end
    end

    assign tmo_hit = (tmo_cnt_q == TMO_LIM);

    // Next-state logic: byte framing, packet apply and timeout recovery.
    // A strobe always wins over a coinciding timeout.
    always_comb begin
        state_d        = state_q;
        hdr_d          = hdr_q;
        byte1_d        = byte1_q;
        first_d        = first_q;
        tmo_cnt_d      = '0;
        packet_valid_d = 1'b0;
        sync_err_d     = 1'b0;
        buttons_d      = buttons_q;
        dx_d           = dx_q;
        dy_d           = dy_q;
        pos_x_d        = pos_x_q;
        pos_y_d        = pos_y_q;
        case (state_q)
            WAIT_B0: begin
                if (rx_data_en) begin
                    if (!first_q && (rx_data == B_ACK || rx_data == B_BAT)) begin
                        // start-up chatter from the mouse, ignored quietly
                    end else if (rx_data[3]) begin
                        hdr_d   = {rx_data[7:4], rx_data[2:0]};
                        state_d = WAIT_B1;
                    end else begin
                        sync_err_d = 1'b1;
                    end
                end
            end
            WAIT_B1: begin
                if (rx_data_en) begin
                    byte1_d = rx_data;
                    state_d = WAIT_B2;
                end else if (tmo_hit) begin
                    state_d    = WAIT_B0;
                    sync_err_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 17'd1;
                end
            end
            WAIT_B2: begin
                if (rx_data_en) begin
                    buttons_d      = hdr_q[2:0];
                    dx_d           = new_dx;
                    dy_d           = new_dy;
                    pos_x_d        = clamp_x;
                    pos_y_d        = clamp_y;
                    packet_valid_d = 1'b1;
                    first_d        = 1'b1;
                    state_d        = WAIT_B0;
                end else if (tmo_hit) begin
                    state_d    = WAIT_B0;
                    sync_err_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 17'd1;
                end
            end
            default: state_d = WAIT_B0;
        endcase
    end

    // State and output registers; reset drops any partial packet.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= WAIT_B0;
            hdr_q          <= '0;
            byte1_q        <= '0;
            first_q        <= 1'b0;
            tmo_cnt_q      <= '0;
            packet_valid_q <= 1'b0;
            sync_err_q     <= 1'b0;
            buttons_q      <= '0;
            dx_q           <= '0;
            dy_q           <= '0;
            pos_x_q        <= X_RST;
            pos_y_q        <= Y_RST;
        end else begin
            state_q        <= state_d;
            hdr_q          <= hdr_d;
            byte1_q        <= byte1_d;
            first_q        <= first_d;
            tmo_cnt_q      <= tmo_cnt_d;
            packet_valid_q <= packet_valid_d;
            sync_err_q     <= sync_err_d;
            buttons_q      <= buttons_d;
            dx_q           <= dx_d;
            dy_q           <= dy_d;
            pos_x_q        <= pos_x_d;
            pos_y_q        <= pos_y_d;
        end
    end

    assign packet_valid = packet_valid_q;
    assign sync_err     = sync_err_q;
    assign buttons      = buttons_q;
    assign dx           = dx_q;
    assign dy           = dy_q;
    assign pos_x        = pos_x_q;
    assign pos_y        = pos_y_q;

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// Directed bench for ps2_mouse_packet: start-up bytes, motion, clamping,
// framing errors, timeout (including the coincident-strobe edge) and reset.
module tb_ps2_mouse_packet;

    localparam int T = 20;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_data_en;
    logic        packet_valid;
    logic [2:0]  buttons;
    logic [8:0]  dx;
    logic [8:0]  dy;
    logic [11:0] pos_x;
    logic [11:0] pos_y;
    logic        sync_err;

    int checks   = 0;
    int failures = 0;

    int exp_x1 [3] = '{197, 69, 0};
    int exp_x2 [6] = '{127, 254, 381, 508, 635, 639};
    int exp_y2 [6] = '{116, 0, 0, 0, 0, 0};
    int exp_y3 [5] = '{127, 254, 381, 479, 479};

    ps2_mouse_packet #(
        .SCREEN_W      (640),
        .SCREEN_H      (480),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset_n     (reset_n),
        .rx_data     (rx_data),
        .rx_data_en  (rx_data_en),
        .packet_valid(packet_valid),
        .buttons     (buttons),
        .dx          (dx),
        .dy          (dy),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .sync_err    (sync_err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One strobe; returns at the negedge where the registered response shows.
    task automatic send(input logic [7:0] b);
        @(negedge CLOCK_50);
        rx_data    = b;
        rx_data_en = 1'b1;
        @(negedge CLOCK_50);
        rx_data_en = 1'b0;
        rx_data    = 8'h00;
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send(b0);
        send(b1);
        send(b2);
    endtask

    // Three strobes on consecutive cycles.
    task automatic send_pkt_b2b(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        @(negedge CLOCK_50);
        rx_data_en = 1'b1;
        rx_data    = b0;
        @(negedge CLOCK_50);
        rx_data    = b1;
        @(negedge CLOCK_50);
        rx_data    = b2;
        @(negedge CLOCK_50);
        rx_data_en = 1'b0;
        rx_data    = 8'h00;
    endtask

    task automatic expect_pkt(input string tag, input logic [2:0] eb, input logic [8:0] edx,
                              input logic [8:0] edy, input int px, input int py);
        chk({tag, ".valid"}, 32'(packet_valid), 32'd1);
        chk({tag, ".sync_err"}, 32'(sync_err), 32'd0);
        chk({tag, ".buttons"}, 32'(buttons), 32'(eb));
        chk({tag, ".dx"}, 32'(dx), 32'(edx));
        chk({tag, ".dy"}, 32'(dy), 32'(edy));
        chk({tag, ".pos_x"}, 32'(pos_x), 32'(px));
        chk({tag, ".pos_y"}, 32'(pos_y), 32'(py));
        @(negedge CLOCK_50);
        chk({tag, ".valid_width"}, 32'(packet_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        rx_data    = 8'h00;
        rx_data_en = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        chk("rst.valid", 32'(packet_valid), 32'd0);
        chk("rst.sync_err", 32'(sync_err), 32'd0);
        chk("rst.buttons", 32'(buttons), 32'd0);
        chk("rst.dx", 32'(dx), 32'd0);
        chk("rst.dy", 32'(dy), 32'd0);
        chk("rst.pos_x", 32'(pos_x), 32'd320);
        chk("rst.pos_y", 32'(pos_y), 32'd240);
        reset_n = 1'b1;

        // start-up ACK / self-test bytes are dropped without error
        send(8'hFA);
        chk("startup.fa", 32'(sync_err), 32'd0);
        send(8'hAA);
        chk("startup.aa", 32'(sync_err), 32'd0);
        send_pkt(8'h08, 8'h00, 8'h00);
        expect_pkt("first", 3'b000, 9'd0, 9'd0, 320, 240);

        // left button, dx=+5, dy=-3 (Y sign in header bit 5), back-to-back
        send_pkt_b2b(8'h29, 8'h05, 8'hFD);
        expect_pkt("motion", 3'b001, 9'd5, 9'h1FD, 325, 243);

        // X left-edge clamp
        for (int i = 0; i < 3; i++) begin
            send_pkt(8'h18, 8'h80, 8'h00);
            expect_pkt("clamp_xlo", 3'b000, 9'h180, 9'd0, exp_x1[i], 243);
        end
        // X right-edge and Y top-edge clamp
        for (int i = 0; i < 6; i++) begin
            send_pkt(8'h08, 8'h7F, 8'h7F);
            expect_pkt("clamp_xhi", 3'b000, 9'h07F, 9'h07F, exp_x2[i], exp_y2[i]);
        end
        // Y bottom-edge clamp
        for (int i = 0; i < 5; i++) begin
            send_pkt(8'h28, 8'h00, 8'h81);
            expect_pkt("clamp_yhi", 3'b000, 9'd0, 9'h181, 639, exp_y3[i]);
        end

        // framing: header without bit 3 is dropped with a one-cycle error
        send(8'h00);
        chk("frame.sync_err", 32'(sync_err), 32'd1);
        chk("frame.valid", 32'(packet_valid), 32'd0);
        @(negedge CLOCK_50);
        chk("frame.sync_width", 32'(sync_err), 32'd0);
        send_pkt(8'h08, 8'h01, 8'h01);
        expect_pkt("resync", 3'b000, 9'd1, 9'd1, 639, 478);
        send_pkt(8'h48, 8'h10, 8'h02);
        expect_pkt("xovf", 3'b000, 9'd0, 9'd2, 639, 476);
        send_pkt(8'h98, 8'hF0, 8'h02);
        expect_pkt("yovf", 3'b000, 9'h1F0, 9'd0, 623, 476);

        // timeout after byte1
        send(8'h08);
        send(8'h01);
        repeat (T) @(negedge CLOCK_50);
        chk("tmo.before", 32'(sync_err), 32'd0);
        @(negedge CLOCK_50);
        chk("tmo.sync_err", 32'(sync_err), 32'd1);
        chk("tmo.valid", 32'(packet_valid), 32'd0);
        @(negedge CLOCK_50);
        chk("tmo.sync_width", 32'(sync_err), 32'd0);
        send_pkt(8'h08, 8'h02, 8'h00);
        expect_pkt("after_tmo", 3'b000, 9'd2, 9'd0, 625, 476);

        // byte2 lands exactly on the expiry cycle: accepted, no error
        send(8'h08);
        send(8'h01);
        repeat (T - 1) @(negedge CLOCK_50);
        send(8'h00);
        expect_pkt("tmo_edge", 3'b000, 9'd1, 9'd0, 626, 476);
        chk("tmo_edge.no_err", 32'(sync_err), 32'd0);

        // asynchronous reset in the middle of a packet
        send(8'h08);
        send(8'h10);
        @(negedge CLOCK_50);
        #2 reset_n = 1'b0;
        #1;
        chk("arst.valid", 32'(packet_valid), 32'd0);
        chk("arst.sync_err", 32'(sync_err), 32'd0);
        chk("arst.buttons", 32'(buttons), 32'd0);
        chk("arst.dx", 32'(dx), 32'd0);
        chk("arst.dy", 32'(dy), 32'd0);
        chk("arst.pos_x", 32'(pos_x), 32'd320);
        chk("arst.pos_y", 32'(pos_y), 32'd240);
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        send_pkt(8'h08, 8'h01, 8'h00);
        expect_pkt("post_rst", 3'b000, 9'd1, 9'd0, 321, 240);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
